// File: rtl/pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : pong_match_controller
// Description : Match-level sequencer for the Pong game. It runs on the pixel
//               clock beside the pixel engine. It holds the ball at centre
//               during the serve delay, enables play, applies ball-exit
//               scoring, picks the serve direction and declares the winner.
//               After the game-over hold time, a button press starts a new
//               match.
// Ports       : CLK            pixel clock
//               RST_N          synchronous active-low reset
//               btns[3:0]      {p1Up, p1Down, p2Up, p2Down}, already synchronised
//               NEXT_FRAME     one-cycle frame strobe
//               ball_out_left  ball left the left edge  -> player 2 scores
//               ball_out_right ball left the right edge -> player 1 scores
//               game_run       ball/paddle motion enable
//               ball_hold      keep ball at screen centre
//               serve_dir      0 = serve left, 1 = serve right
//               score1/score2  player scores
//               winner         00 none, 01 player 1, 10 player 2
//               state_o        current state encoding (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module pong_match_controller #(
  parameter int WIN_SCORE            = 7,
  parameter int SERVE_DELAY_FRAMES   = 60,
  parameter int GAMEOVER_HOLD_FRAMES = 120,
  parameter bit BUTTON_LOW_ACTIVE    = 1'b1,
  localparam int SCORE_WID           = $clog2(WIN_SCORE + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [3:0]           btns,
  input  logic                 NEXT_FRAME,
  input  logic                 ball_out_left,
  input  logic                 ball_out_right,
  output logic                 game_run,
  output logic                 ball_hold,
  output logic                 serve_dir,
  output logic [SCORE_WID-1:0] score1,
  output logic [SCORE_WID-1:0] score2,
  output logic [1:0]           winner,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [SCORE_WID-1:0] c_win_score = SCORE_WID'(WIN_SCORE);
  localparam logic [7:0]           c_serve_cnt = 8'(SERVE_DELAY_FRAMES);
  localparam logic [7:0]           c_hold_cnt  = 8'(GAMEOVER_HOLD_FRAMES);

  state_t                 state_q,     state_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;
  logic [SCORE_WID-1:0]   score1_q,    score1_d;
  logic [SCORE_WID-1:0]   score2_q,    score2_d;
  logic                   serve_dir_q, serve_dir_d;
  logic [1:0]             winner_q,    winner_d;
  logic                   press_q,     press_d;
  logic                   game_run_q,  game_run_d;
  logic                   ball_hold_q, ball_hold_d;

  logic [3:0]             w_act;
  logic                   w_any;
  logic                   w_press_ev;
  logic [7:0]             w_frame_inc;
  logic [SCORE_WID-1:0]   w_score1_inc;
  logic [SCORE_WID-1:0]   w_score2_inc;

  always_comb begin
    w_act        = BUTTON_LOW_ACTIVE ? ~btns : btns;
    w_any        = |w_act;
    // Rising edge of "any button down"; press_q powers up at 1 so a button
    // held through reset is not seen as a fresh press.
    w_press_ev   = w_any & ~press_q;
    w_frame_inc  = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;
    // Saturating guards: scores can never pass the winning score.
    w_score1_inc = (score1_q >= c_win_score) ? score1_q : score1_q + SCORE_WID'(1);
    w_score2_inc = (score2_q >= c_win_score) ? score2_q : score2_q + SCORE_WID'(1);
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    press_d     = w_any;

    case (state_q)
      ST_IDLE: begin
        score1_d = '0;
        score2_d = '0;
        if (w_press_ev) begin
          state_d     = ST_SERVE;
          frame_cnt_d = 8'd0;
        end
      end

      ST_SERVE: begin
        if (NEXT_FRAME) begin
          frame_cnt_d = w_frame_inc;
          if (w_frame_inc >= c_serve_cnt) begin
            state_d = ST_PLAY;
          end
        end
      end

      ST_PLAY: begin
        if (ball_out_left && ball_out_right) begin
          // Simultaneous exits are treated as a void rally: re-serve.
          state_d     = ST_SERVE;
          frame_cnt_d = 8'd0;
        end else if (ball_out_right) begin
          score1_d    = w_score1_inc;
          serve_dir_d = 1'b1;
          state_d     = ST_POINT;
        end else if (ball_out_left) begin
          score2_d    = w_score2_inc;
          serve_dir_d = 1'b0;
          state_d     = ST_POINT;
        end
      end

      ST_POINT: begin
        frame_cnt_d = 8'd0;
        if (score1_q == c_win_score) begin
          winner_d = 2'b01;
          state_d  = ST_GAME_OVER;
        end else if (score2_q == c_win_score) begin
          winner_d = 2'b10;
          state_d  = ST_GAME_OVER;
        end else begin
          state_d  = ST_SERVE;
        end
      end

      ST_GAME_OVER: begin
        if (frame_cnt_q >= c_hold_cnt) begin
          if (w_press_ev) begin
            score1_d    = '0;
            score2_d    = '0;
            winner_d    = 2'b00;
            frame_cnt_d = 8'd0;
            state_d     = ST_SERVE;
          end
        end else if (NEXT_FRAME) begin
          frame_cnt_d = w_frame_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    game_run_d  = (state_d == ST_PLAY);
    ball_hold_d = (state_d != ST_PLAY);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= 8'd0;
      score1_q    <= '0;
      score2_q    <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 2'b00;
      press_q     <= 1'b1;
      game_run_q  <= 1'b0;
      ball_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      press_q     <= press_d;
      game_run_q  <= game_run_d;
      ball_hold_q <= ball_hold_d;
    end
  end

  assign game_run  = game_run_q;
  assign ball_hold = ball_hold_q;
  assign serve_dir = serve_dir_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign winner    = winner_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_match_controller
// Description : Directed self-checking bench for pong_match_controller.
//               Instance A (WIN_SCORE=2) covers the match flow. Instance B
//               (WIN_SCORE=7) covers reset in the middle of a match.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_match_controller;

  logic       CLK;
  logic       rst_n_a, rst_n_b;
  logic [3:0] btns;
  logic       nf, bol, bor;

  logic       run_a, hold_a, dir_a;
  logic [1:0] s1_a, s2_a, win_a;
  logic [2:0] st_a;

  logic       run_b, hold_b, dir_b;
  logic [2:0] s1_b, s2_b;
  logic [1:0] win_b;
  logic [2:0] st_b;

  int errors = 0;
  int checks = 0;

  pong_match_controller #(
    .WIN_SCORE(2), .SERVE_DELAY_FRAMES(3), .GAMEOVER_HOLD_FRAMES(4), .BUTTON_LOW_ACTIVE(1'b1)
  ) dut_a (
    .CLK(CLK), .RST_N(rst_n_a), .btns(btns), .NEXT_FRAME(nf),
    .ball_out_left(bol), .ball_out_right(bor),
    .game_run(run_a), .ball_hold(hold_a), .serve_dir(dir_a),
    .score1(s1_a), .score2(s2_a), .winner(win_a), .state_o(st_a)
  );

  pong_match_controller #(
    .WIN_SCORE(7), .SERVE_DELAY_FRAMES(3), .GAMEOVER_HOLD_FRAMES(4), .BUTTON_LOW_ACTIVE(1'b1)
  ) dut_b (
    .CLK(CLK), .RST_N(rst_n_b), .btns(btns), .NEXT_FRAME(nf),
    .ball_out_left(bol), .ball_out_right(bor),
    .game_run(run_b), .ball_hold(hold_b), .serve_dir(dir_b),
    .score1(s1_b), .score2(s2_b), .winner(win_b), .state_o(st_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_nf();
    nf = 1'b1; step(1); nf = 1'b0; step(1);
  endtask

  task automatic to_play();
    repeat (3) pulse_nf();
  endtask

  task automatic press();
    btns = 4'b1110; step(1); btns = 4'b1111; step(1);
  endtask

  task automatic test_reset();
    btns = 4'b1110;
    rst_n_a = 1'b0;
    step(3);
    checks++; if (st_a !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", st_a); end
    checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL rst_game_run: got %0b want 0", run_a); end
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL rst_ball_hold: got %0b want 1", hold_a); end
    checks++; if (dir_a !== 1'b0) begin errors++; $display("FAIL rst_serve_dir: got %0b want 0", dir_a); end
    checks++; if (s1_a !== 2'd0 || s2_a !== 2'd0) begin errors++; $display("FAIL rst_scores: got %0d/%0d want 0/0", s1_a, s2_a); end
    checks++; if (win_a !== 2'b00) begin errors++; $display("FAIL rst_winner: got %b want 00", win_a); end
    // Button still held after reset release must not start a match.
    rst_n_a = 1'b1;
    step(3);
    checks++; if (st_a !== 3'd0) begin errors++; $display("FAIL held_btn_idle: got %0d want 0", st_a); end
  endtask

  task automatic test_start();
    btns = 4'b1111; step(1);
    btns = 4'b1110; step(1);
    checks++; if (st_a !== 3'd1) begin errors++; $display("FAIL start_state: got %0d want 1", st_a); end
    checks++; if (hold_a !== 1'b1 || run_a !== 1'b0) begin errors++; $display("FAIL start_hold: got hold=%0b run=%0b want 1/0", hold_a, run_a); end
    btns = 4'b1111; step(1);
  endtask

  task automatic test_serve();
    pulse_nf(); pulse_nf();
    checks++; if (run_a !== 1'b0 || st_a !== 3'd1) begin errors++; $display("FAIL serve_2frames: got run=%0b st=%0d want 0/1", run_a, st_a); end
    nf = 1'b1; step(1); nf = 1'b0;
    checks++; if (run_a !== 1'b1 || hold_a !== 1'b0 || st_a !== 3'd2) begin errors++; $display("FAIL serve_3frames: got run=%0b hold=%0b st=%0d want 1/0/2", run_a, hold_a, st_a); end
    step(1);
  endtask

  task automatic test_point();
    bor = 1'b1; step(1); bor = 1'b0;
    checks++; if (st_a !== 3'd3 || s1_a !== 2'd1 || dir_a !== 1'b1 || run_a !== 1'b0) begin errors++; $display("FAIL point_p1: got st=%0d s1=%0d dir=%0b run=%0b want 3/1/1/0", st_a, s1_a, dir_a, run_a); end
    step(1);
    checks++; if (st_a !== 3'd1) begin errors++; $display("FAIL point_to_serve: got %0d want 1", st_a); end
    bol = 1'b1; step(1); bol = 1'b0; step(1);
    checks++; if (s2_a !== 2'd0 || st_a !== 3'd1) begin errors++; $display("FAIL exit_in_serve: got s2=%0d st=%0d want 0/1", s2_a, st_a); end
  endtask

  task automatic test_both_exits();
    to_play();
    checks++; if (st_a !== 3'd2) begin errors++; $display("FAIL replay_state: got %0d want 2", st_a); end
    bol = 1'b1; bor = 1'b1; step(1); bol = 1'b0; bor = 1'b0;
    checks++; if (st_a !== 3'd1 || s1_a !== 2'd1 || s2_a !== 2'd0 || dir_a !== 1'b1) begin errors++; $display("FAIL both_exits: got st=%0d s1=%0d s2=%0d dir=%0b want 1/1/0/1", st_a, s1_a, s2_a, dir_a); end
    step(1);
  endtask

  task automatic test_win_and_restart();
    to_play();
    bol = 1'b1; step(1); bol = 1'b0;
    checks++; if (st_a !== 3'd3 || s2_a !== 2'd1 || dir_a !== 1'b0) begin errors++; $display("FAIL point_p2: got st=%0d s2=%0d dir=%0b want 3/1/0", st_a, s2_a, dir_a); end
    step(1);
    to_play();
    bol = 1'b1; step(1); bol = 1'b0;
    checks++; if (st_a !== 3'd3 || s2_a !== 2'd2 || win_a !== 2'b00) begin errors++; $display("FAIL final_point: got st=%0d s2=%0d win=%b want 3/2/00", st_a, s2_a, win_a); end
    step(1);
    checks++; if (st_a !== 3'd4 || win_a !== 2'b10 || run_a !== 1'b0) begin errors++; $display("FAIL game_over: got st=%0d win=%b run=%0b want 4/10/0", st_a, win_a, run_a); end
    pulse_nf(); pulse_nf();
    press();
    checks++; if (st_a !== 3'd4 || win_a !== 2'b10 || s1_a !== 2'd1) begin errors++; $display("FAIL early_press: got st=%0d win=%b s1=%0d want 4/10/1", st_a, win_a, s1_a); end
    pulse_nf(); pulse_nf();
    btns = 4'b1110; step(1);
    checks++; if (st_a !== 3'd1 || s1_a !== 2'd0 || s2_a !== 2'd0 || win_a !== 2'b00 || dir_a !== 1'b0) begin errors++; $display("FAIL restart: got st=%0d s1=%0d s2=%0d win=%b dir=%0b want 1/0/0/00/0", st_a, s1_a, s2_a, win_a, dir_a); end
    btns = 4'b1111; step(1);
  endtask

  task automatic test_reset_mid_match();
    rst_n_b = 1'b1; step(1);
    press();
    checks++; if (st_b !== 3'd1) begin errors++; $display("FAIL b_start: got %0d want 1", st_b); end
    for (int i = 0; i < 3; i++) begin
      to_play();
      bor = 1'b1; step(1); bor = 1'b0; step(1);
    end
    to_play();
    checks++; if (st_b !== 3'd2 || s1_b !== 3'd3 || dir_b !== 1'b1) begin errors++; $display("FAIL b_play_s3: got st=%0d s1=%0d dir=%0b want 2/3/1", st_b, s1_b, dir_b); end
    rst_n_b = 1'b0; bor = 1'b1; step(1); bor = 1'b0;
    checks++; if (st_b !== 3'd0 || s1_b !== 3'd0 || s2_b !== 3'd0) begin errors++; $display("FAIL b_rst_state: got st=%0d s1=%0d s2=%0d want 0/0/0", st_b, s1_b, s2_b); end
    checks++; if (run_b !== 1'b0 || hold_b !== 1'b1 || dir_b !== 1'b0 || win_b !== 2'b00) begin errors++; $display("FAIL b_rst_outputs: got run=%0b hold=%0b dir=%0b win=%b want 0/1/0/00", run_b, hold_b, dir_b, win_b); end
    rst_n_b = 1'b1; step(1);
  endtask

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    btns    = 4'b1110;
    nf      = 1'b0;
    bol     = 1'b0;
    bor     = 1'b0;
    test_reset();
    test_start();
    test_serve();
    test_point();
    test_both_exits();
    test_win_and_restart();
    test_reset_mid_match();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_match_controller.md
Name: pong_match_controller

Overview:
- Match-level sequencer for the Pong design; runs on the pixel clock beside the pixel engine.
- Consumes the pixel bus frame strobe, ball-exit events from the pixel engine and the four player buttons.
- Decides when the ball is held at centre, when play runs, which side serves, the scores and the winner.
- Its outputs gate ball motion in the pixel engine and feed the score overlay.

Parameters:
- WIN_SCORE, 7, score that ends the match (1..15).
- SERVE_DELAY_FRAMES, 60, frames the ball is held at centre before each serve (1..255).
- GAMEOVER_HOLD_FRAMES, 120, minimum frames in GAME_OVER before a restart press is accepted (1..255).
- BUTTON_LOW_ACTIVE, 1, 1 = button pressed when its input is 0.
- SCORE_WID, $clog2(WIN_SCORE+1), score output width (derived, not overridden).

Ports:
- CLK  in  1  pixel clock; the only clock.
- RST_N  in  1  synchronous reset, active-low.
- btns  in  4  raw player buttons {p1Up, p1Down, p2Up, p2Down}, already synchronised.
- NEXT_FRAME  in  1  one-cycle strobe per frame from the pixel bus.
- ball_out_left  in  1  one-cycle pulse: ball passed the left edge, so player 2 scores.
- ball_out_right  in  1  one-cycle pulse: ball passed the right edge, so player 1 scores.
- game_run  out  1  ball and paddle motion enabled.
- ball_hold  out  1  pixel engine keeps the ball at screen centre.
- serve_dir  out  1  0 = next serve travels left, 1 = right.
- score1  out  SCORE_WID  player 1 score.
- score2  out  SCORE_WID  player 2 score.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-low (RST_N), sampled on the rising edge of CLK.
- Reset values: state IDLE, game_run 0, ball_hold 1, serve_dir 0, score1 0, score2 0, winner 00, frame counter 0, press_q 1.
  - press_q resets to 1 so a button held through reset does not start a match.
- Press detection:
  - act = BUTTON_LOW_ACTIVE ? ~btns : btns; any = |act.
  - press_ev = any & ~press_q; press_q <= any every cycle.
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4; encodings 5..7 return to IDLE on the next cycle.
- IDLE:
  - Scores are 0.
  - press_ev -> SERVE, frame counter cleared.
- SERVE:
  - Counter increments on each NEXT_FRAME.
  - When the NEXT_FRAME that brings the count to SERVE_DELAY_FRAMES occurs, move to PLAY on the next edge.
- PLAY:
  - ball_out_right alone -> score1+1, serve_dir <= 1 (serve toward the loser), go to POINT.
  - ball_out_left alone -> score2+1, serve_dir <= 0, go to POINT.
  - Both asserted in the same cycle -> no score change, serve_dir unchanged, go to SERVE.
- POINT (1 cycle):
  - If the updated score equals WIN_SCORE, set winner and go to GAME_OVER.
  - Otherwise go to SERVE.
  - Frame counter is cleared on exit.
- GAME_OVER:
  - Counter increments on NEXT_FRAME and saturates at GAMEOVER_HOLD_FRAMES.
  - press_ev is ignored until the counter reaches GAMEOVER_HOLD_FRAMES.
  - After that, press_ev -> clear scores and winner, keep serve_dir, go to SERVE.
- Output derivation (all outputs registered): game_run = (state==PLAY); ball_hold = (state!=PLAY); state_o = state.
- Latency: a triggering input at edge N is reflected on the outputs after edge N+1.
- Ignored inputs:
  - ball_out_left/right are ignored in every state except PLAY.
  - press_ev is ignored in SERVE, PLAY and POINT.
  - NEXT_FRAME coinciding with an ignored event has no extra effect.
- Width rules:
  - Scores never exceed WIN_SCORE; increments are saturating as a guard.
  - Frame counter is 8 bits and saturating.
- Reset mid-match (RST_N low in any state, including a cycle carrying an exit pulse) returns all state to reset values at that edge; no score update occurs.

Test Plan:
- Hold btns=4'b1110 (p1Up active, low-active) across reset release -> remain IDLE; release then press again -> SERVE one cycle after the press edge, ball_hold=1.
- In SERVE with SERVE_DELAY_FRAMES=3, pulse NEXT_FRAME 3 times -> game_run=1 one cycle after the 3rd strobe; after only 2 strobes game_run stays 0.
- In PLAY, pulse ball_out_right -> score1=1, serve_dir=1, state_o goes 3 then 1, game_run=0; pulse ball_out_left in SERVE -> score2 unchanged.
- In PLAY, assert ball_out_left and ball_out_right in the same cycle -> scores unchanged, serve_dir unchanged, state SERVE.
- WIN_SCORE=2, player 2 scores twice -> winner=10, state GAME_OVER; with GAMEOVER_HOLD_FRAMES=4, a press after 2 frames is ignored, a press after 4 frames clears scores and winner and enters SERVE.
- Assert RST_N=0 in PLAY with score1=3 -> next cycle all outputs at reset values, state_o=0.
